// File: rtl/interlaken_rx_lane_ctrl_if.sv
// Purpose: lane-side signal bundle between gearbox/descrambler glue and the rx lane bring-up controller.
// Latency: none, wires only; the controller registers every output it drives here.
// Backpressure: none, level/pulse signals with no handshake.
interface interlaken_rx_lane_ctrl_if;
  logic       enable;             // lane enable, low forces IDLE
  logic [1:0] rx_header;          // 64b/67b sync header from gearbox
  logic       rx_header_vld;      // rx_header qualifier
  logic       descr_locked;       // descrambler LOCKED
  logic       bitslip;            // one-cycle slip request to gearbox
  logic       descr_passthrough;  // high holds descrambler in reset state
  logic       hdr_locked;         // sync-header lock status
  logic       lane_up;            // lane fully aligned
  logic [2:0] state;              // FSM state encoding
  logic [7:0] lane_down_cnt;      // saturating count of lane_up falls

  // Stimulus / environment side
  modport master (
    output enable, rx_header, rx_header_vld, descr_locked,
    input  bitslip, descr_passthrough, hdr_locked, lane_up, state, lane_down_cnt
  );

  // Controller side
  modport slave (
    input  enable, rx_header, rx_header_vld, descr_locked,
    output bitslip, descr_passthrough, hdr_locked, lane_up, state, lane_down_cnt
  );
endinterface

// File: rtl/interlaken_rx_lane_ctrl.sv
// Purpose: per-lane rx bring-up: bitslip hunt for sync-header lock, then descrambler lock supervision.
// Latency: every output registered, visible the cycle after the qualifying input.
// Backpressure: none; headers with rx_header_vld low are ignored by all header counters.
module interlaken_rx_lane_ctrl #(
  parameter int HDR_LOCK_CNT  = 64,
  parameter int HDR_WIN       = 64,
  parameter int HDR_BAD_MAX   = 16,
  parameter int SLIP_WAIT     = 32,
  parameter int DESCR_TIMEOUT = 4096,
  parameter int DESCR_RETRIES = 3
) (
  input  logic                    user_clk_i,
  input  logic                    system_reset_n_i,
  interlaken_rx_lane_ctrl_if.slave lane
);

  localparam int SH_W  = $clog2(HDR_LOCK_CNT) + 1;
  localparam int WIN_W = $clog2(HDR_WIN) + 1;
  localparam int BAD_W = $clog2(HDR_BAD_MAX) + 1;
  localparam int SLP_W = $clog2(SLIP_WAIT) + 1;
  localparam int TMR_W = $clog2(DESCR_TIMEOUT) + 1;
  localparam int RTY_W = $clog2(DESCR_RETRIES) + 1;

  // Terminal values: each counter acts on the event that would bring it to its limit.
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(HDR_LOCK_CNT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(HDR_WIN - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(HDR_BAD_MAX - 1);
  localparam logic [SLP_W-1:0] SLP_LAST = SLP_W'(SLIP_WAIT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DESCR_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(DESCR_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_HUNT       = 3'b001,
    ST_SLIP       = 3'b010,
    ST_DESCR_WAIT = 3'b011,
    ST_REARM      = 3'b100,
    ST_UP         = 3'b101
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [SLP_W-1:0]  slip_cnt_q, slip_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic              bitslip_q, bitslip_d;
  logic              pass_q, pass_d;
  logic              hdr_locked_q, hdr_locked_d;
  logic              lane_up_q, lane_up_d;
  logic [7:0]        down_cnt_q, down_cnt_d;

  logic       hdr_good;
  logic       hdr_bad;
  logic       hdr_loss;
  logic [7:0] down_cnt_inc;

  // 01/10 are legal sync headers, 00/11 are not; only qualified cycles count.
  assign hdr_good     = lane.rx_header_vld & (lane.rx_header[1] ^ lane.rx_header[0]);
  assign hdr_bad      = lane.rx_header_vld & ~(lane.rx_header[1] ^ lane.rx_header[0]);
  assign down_cnt_inc = (down_cnt_q == 8'hFF) ? 8'hFF : down_cnt_q + 8'd1;

  assign lane.bitslip           = bitslip_q;
  assign lane.descr_passthrough = pass_q;
  assign lane.hdr_locked        = hdr_locked_q;
  assign lane.lane_up           = lane_up_q;
  assign lane.state             = state_q;
  assign lane.lane_down_cnt     = down_cnt_q;

  // Next-state and registered-output decode; enable low overrides everything but reset.
  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    bitslip_d    = 1'b0;
    pass_d       = pass_q;
    hdr_locked_d = hdr_locked_q;
    lane_up_d    = lane_up_q;
    down_cnt_d   = down_cnt_q;
    hdr_loss     = 1'b0;

    if (!lane.enable) begin
      state_d      = ST_IDLE;
      sh_cnt_d     = '0;
      slip_cnt_d   = '0;
      timer_d      = '0;
      retry_d      = '0;
      win_cnt_d    = '0;
      bad_cnt_d    = '0;
      pass_d       = 1'b1;
      hdr_locked_d = 1'b0;
      lane_up_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sh_cnt_d = '0;
          state_d  = ST_HUNT;
        end

        ST_HUNT: begin
          if (hdr_bad) begin
            bitslip_d  = 1'b1;
            sh_cnt_d   = '0;
            slip_cnt_d = '0;
            state_d    = ST_SLIP;
          end else if (hdr_good) begin
            if (sh_cnt_q == SH_LAST) begin
              sh_cnt_d     = '0;
              hdr_locked_d = 1'b1;
              pass_d       = 1'b0;
              timer_d      = '0;
              retry_d      = '0;
              win_cnt_d    = '0;
              bad_cnt_d    = '0;
              state_d      = ST_DESCR_WAIT;
            end else begin
              sh_cnt_d = sh_cnt_q + SH_W'(1);
            end
          end
        end

        // Gearbox needs time to settle after a slip; headers are not looked at here.
        ST_SLIP: begin
          if (slip_cnt_q == SLP_LAST) begin
            slip_cnt_d = '0;
            sh_cnt_d   = '0;
            state_d    = ST_HUNT;
          end else begin
            slip_cnt_d = slip_cnt_q + SLP_W'(1);
          end
        end

        ST_DESCR_WAIT, ST_REARM, ST_UP: begin
          // Header monitor; the last allowed bad header beats a coincident window end.
          if (hdr_bad && (bad_cnt_q == BAD_LAST)) begin
            hdr_loss = 1'b1;
          end else if (lane.rx_header_vld) begin
            if (win_cnt_q == WIN_LAST) begin
              win_cnt_d = '0;
              bad_cnt_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + WIN_W'(1);
              if (hdr_bad) bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end

          if (hdr_loss) begin
            if (lane_up_q) down_cnt_d = down_cnt_inc;
            lane_up_d    = 1'b0;
            hdr_locked_d = 1'b0;
            pass_d       = 1'b1;
            win_cnt_d    = '0;
            bad_cnt_d    = '0;
            sh_cnt_d     = '0;
            state_d      = ST_HUNT;
          end else if (state_q == ST_REARM) begin
            pass_d  = 1'b0;
            timer_d = '0;
            state_d = ST_DESCR_WAIT;
          end else if (state_q == ST_UP) begin
            // Descrambler dropped lock: keep it out of reset and let it re-lock on its own.
            if (!lane.descr_locked) begin
              lane_up_d  = 1'b0;
              down_cnt_d = down_cnt_inc;
              timer_d    = '0;
              retry_d    = '0;
              state_d    = ST_DESCR_WAIT;
            end
          end else begin
            if (lane.descr_locked) begin
              lane_up_d = 1'b1;
              state_d   = ST_UP;
            end else if (timer_q == TMR_LAST) begin
              if (retry_q < RTY_MAX) begin
                retry_d = retry_q + RTY_W'(1);
                pass_d  = 1'b1;
                state_d = ST_REARM;
              end else begin
                // Retries exhausted: header alignment is suspect, slip and hunt again.
                hdr_locked_d = 1'b0;
                pass_d       = 1'b1;
                bitslip_d    = 1'b1;
                slip_cnt_d   = '0;
                state_d      = ST_SLIP;
              end
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end

        default: begin
          state_d      = ST_IDLE;
          pass_d       = 1'b1;
          hdr_locked_d = 1'b0;
          lane_up_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counters and output registers; async reset to the idle/passthrough condition.
  always_ff @(posedge user_clk_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      state_q      <= ST_IDLE;
      sh_cnt_q     <= '0;
      slip_cnt_q   <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      bitslip_q    <= 1'b0;
      pass_q       <= 1'b1;
      hdr_locked_q <= 1'b0;
      lane_up_q    <= 1'b0;
      down_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      bitslip_q    <= bitslip_d;
      pass_q       <= pass_d;
      hdr_locked_q <= hdr_locked_d;
      lane_up_q    <= lane_up_d;
      down_cnt_q   <= down_cnt_d;
    end
  end

endmodule

// File: tb/tb_interlaken_rx_lane_ctrl.sv
// Purpose: bench for interlaken_rx_lane_ctrl: directed bring-up steps plus randomized traffic vs a reference model.
// Latency: outputs sampled 1 time unit after each rising edge, compared with the model's post-edge view.
// Backpressure: none; inputs are driven with blocking assignments between edges.
module tb_interlaken_rx_lane_ctrl;
  localparam int LOCK_N  = 64;
  localparam int WIN_N   = 64;
  localparam int BAD_N   = 16;
  localparam int SLIP_N  = 32;
  localparam int TO_N    = 16;
  localparam int RETRY_N = 3;

  localparam int S_IDLE = 0, S_HUNT = 1, S_SLIP = 2, S_DW = 3, S_REARM = 4, S_UP = 5;

  logic clk = 1'b0;
  logic rst_n;

  interlaken_rx_lane_ctrl_if lif ();

  interlaken_rx_lane_ctrl #(
    .HDR_LOCK_CNT (LOCK_N),
    .HDR_WIN      (WIN_N),
    .HDR_BAD_MAX  (BAD_N),
    .SLIP_WAIT    (SLIP_N),
    .DESCR_TIMEOUT(TO_N),
    .DESCR_RETRIES(RETRY_N)
  ) dut (
    .user_clk_i      (clk),
    .system_reset_n_i(rst_n),
    .lane            (lif)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: counts elapsed events rather than terminal-value compares.
  int m_st, m_sh, m_slip, m_tmr, m_rty, m_win, m_bad, m_ldc;
  bit m_bs, m_pt, m_hl, m_up;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_sh = 0; m_slip = 0; m_tmr = 0; m_rty = 0; m_win = 0; m_bad = 0;
    m_ldc = 0; m_bs = 0; m_pt = 1; m_hl = 0; m_up = 0;
  endtask

  task automatic model_clock();
    bit good, bad, loss;
    good = lif.rx_header_vld && (lif.rx_header == 2'b01 || lif.rx_header == 2'b10);
    bad  = lif.rx_header_vld && !good;
    m_bs = 0;
    if (!lif.enable) begin
      m_st = S_IDLE; m_pt = 1; m_hl = 0; m_up = 0;
      m_sh = 0; m_slip = 0; m_tmr = 0; m_rty = 0; m_win = 0; m_bad = 0;
      return;
    end
    case (m_st)
      S_IDLE: begin m_st = S_HUNT; m_sh = 0; end
      S_HUNT: begin
        if (bad) begin m_bs = 1; m_sh = 0; m_slip = 0; m_st = S_SLIP; end
        else if (good) begin
          m_sh++;
          if (m_sh == LOCK_N) begin
            m_sh = 0; m_hl = 1; m_pt = 0; m_tmr = 0; m_rty = 0; m_win = 0; m_bad = 0; m_st = S_DW;
          end
        end
      end
      S_SLIP: begin
        m_slip++;
        if (m_slip == SLIP_N) begin m_slip = 0; m_sh = 0; m_st = S_HUNT; end
      end
      default: begin
        loss = 0;
        if (lif.rx_header_vld) begin
          m_win++;
          if (bad) m_bad++;
          if (m_bad == BAD_N) loss = 1;
          else if (m_win == WIN_N) begin m_win = 0; m_bad = 0; end
        end
        if (loss) begin
          if (m_up && m_ldc < 255) m_ldc++;
          m_up = 0; m_hl = 0; m_pt = 1; m_win = 0; m_bad = 0; m_sh = 0; m_st = S_HUNT;
        end else if (m_st == S_REARM) begin
          m_pt = 0; m_tmr = 0; m_st = S_DW;
        end else if (m_st == S_UP) begin
          if (!lif.descr_locked) begin
            m_up = 0; if (m_ldc < 255) m_ldc++;
            m_tmr = 0; m_rty = 0; m_st = S_DW;
          end
        end else if (lif.descr_locked) begin
          m_up = 1; m_st = S_UP;
        end else begin
          m_tmr++;
          if (m_tmr == TO_N) begin
            if (m_rty < RETRY_N) begin m_rty++; m_pt = 1; m_st = S_REARM; end
            else begin m_hl = 0; m_pt = 1; m_bs = 1; m_slip = 0; m_st = S_SLIP; end
          end
        end
      end
    endcase
  endtask

  function automatic logic [14:0] dut_vec();
    return {lif.state, lif.bitslip, lif.descr_passthrough, lif.hdr_locked, lif.lane_up, lif.lane_down_cnt};
  endfunction

  function automatic logic [14:0] model_vec();
    return {3'(m_st), m_bs, m_pt, m_hl, m_up, 8'(m_ldc)};
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
  endfunction

  // One clock: apply inputs, advance model at the edge, compare just after it.
  task automatic cyc(input logic en, input logic [1:0] h, input logic v, input logic lk);
    lif.enable = en; lif.rx_header = h; lif.rx_header_vld = v; lif.descr_locked = lk;
    @(posedge clk);
    model_clock();
    #1;
    chk("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic count_slip(output int n);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      if (lif.state != 3'b010) break;
      n++;
    end
  endtask

  task automatic lock_up();
    for (int i = 0; i < LOCK_N; i++) cyc(1'b1, good_hdr(), 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b1);
  endtask

  initial begin
    int pulses[$];
    int slip_at, nslip, pass_cnt, bad_rate;
    bit pt_seen;
    logic [63:0] badmask;
    logic lk;

    lif.enable = 1'b0; lif.rx_header = 2'b00; lif.rx_header_vld = 1'b0; lif.descr_locked = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_state", 32'(lif.state), 32'd0);
    chk("rst_bitslip", 32'(lif.bitslip), 32'd0);
    chk("rst_pass", 32'(lif.descr_passthrough), 32'd1);
    chk("rst_hdr", 32'(lif.hdr_locked), 32'd0);
    chk("rst_up", 32'(lif.lane_up), 32'd0);
    chk("rst_ldc", 32'(lif.lane_down_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Header lock after 64 alternating valid headers
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    chk("hunt_entry", 32'(lif.state), 32'd1);
    for (int i = 0; i < LOCK_N; i++) begin
      cyc(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0);
      if (i == LOCK_N - 2) chk("lock_not_early", 32'(lif.hdr_locked), 32'd0);
    end
    chk("lock_hdr", 32'(lif.hdr_locked), 32'd1);
    chk("lock_pass", 32'(lif.descr_passthrough), 32'd0);
    chk("lock_state", 32'(lif.state), 32'd3);

    // Descrambler timeout / re-arm sequence
    slip_at = -1; pass_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      cyc(1'b1, good_hdr(), 1'b1, 1'b0);
      if (lif.state == 3'b010) begin
        slip_at = c;
        chk("to_bitslip", 32'(lif.bitslip), 32'd1);
        chk("to_hdr", 32'(lif.hdr_locked), 32'd0);
        break;
      end
      if (lif.descr_passthrough) begin pulses.push_back(c); pass_cnt++; end
    end
    chk("to_pulses", 32'(pass_cnt), 32'(RETRY_N));
    chk("to_first", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'(TO_N));
    chk("to_gap1", 32'((pulses.size() > 1) ? pulses[1] - pulses[0] : -1), 32'(TO_N + 1));
    chk("to_gap2", 32'((pulses.size() > 2) ? pulses[2] - pulses[1] : -1), 32'(TO_N + 1));
    chk("to_slip_at", 32'(slip_at), 32'((RETRY_N + 1) * (TO_N + 1) - 1));
    count_slip(nslip);
    chk("to_slip_len", 32'(nslip), 32'(SLIP_N));
    chk("to_back_hunt", 32'(lif.state), 32'd1);

    // Invalid header during hunt after 10 valid
    for (int i = 0; i < 10; i++) cyc(1'b1, good_hdr(), 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 1'b0);
    chk("hunt_bitslip", 32'(lif.bitslip), 32'd1);
    chk("hunt_slip", 32'(lif.state), 32'd2);
    cyc(1'b1, 2'b01, 1'b1, 1'b0);
    chk("hunt_bitslip_1cyc", 32'(lif.bitslip), 32'd0);
    count_slip(nslip);
    chk("hunt_slip_len", 32'(nslip + 1), 32'(SLIP_N));
    chk("hunt_back", 32'(lif.state), 32'd1);
    // Count restarted at zero: 63 valid (with unqualified gaps) keep hunting, 64th locks
    for (int i = 0; i < LOCK_N - 1; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b1, 2'b11, 1'b0, 1'b0);
      cyc(1'b1, good_hdr(), 1'b1, 1'b0);
    end
    chk("sh_63", 32'(lif.state), 32'd1);
    cyc(1'b1, good_hdr(), 1'b1, 1'b0);
    chk("sh_64", 32'(lif.state), 32'd3);

    // Lane up, then header-monitor windows
    cyc(1'b1, 2'b11, 1'b0, 1'b1);
    chk("up_state", 32'(lif.state), 32'd5);
    chk("up_flag", 32'(lif.lane_up), 32'd1);
    badmask = '0; nslip = 0;
    for (int i = 0; i < 10000 && nslip < BAD_N - 1; i++) begin
      int p;
      p = $urandom_range(0, 63);
      if (!badmask[p]) begin badmask[p] = 1'b1; nslip++; end
    end
    for (int j = 0; j < WIN_N; j++) begin
      if ($urandom_range(0, 4) == 0) cyc(1'b1, 2'b00, 1'b0, 1'b1);
      cyc(1'b1, badmask[j] ? bad_hdr() : good_hdr(), 1'b1, 1'b1);
    end
    chk("win1_up", 32'(lif.lane_up), 32'd1);
    for (int j = 0; j < 20; j++) cyc(1'b1, good_hdr(), 1'b1, 1'b1);
    for (int j = 0; j < BAD_N - 1; j++) cyc(1'b1, bad_hdr(), 1'b1, 1'b1);
    chk("win2_15_up", 32'(lif.lane_up), 32'd1);
    chk("win2_15_hdr", 32'(lif.hdr_locked), 32'd1);
    cyc(1'b1, bad_hdr(), 1'b1, 1'b1);
    chk("loss_up", 32'(lif.lane_up), 32'd0);
    chk("loss_hdr", 32'(lif.hdr_locked), 32'd0);
    chk("loss_pass", 32'(lif.descr_passthrough), 32'd1);
    chk("loss_ldc", 32'(lif.lane_down_cnt), 32'd1);
    chk("loss_state", 32'(lif.state), 32'd1);

    // 16th bad header lands on the window's last header: loss still wins
    lock_up();
    for (int j = 0; j < WIN_N - BAD_N; j++) cyc(1'b1, good_hdr(), 1'b1, 1'b1);
    for (int j = 0; j < BAD_N - 1; j++) cyc(1'b1, bad_hdr(), 1'b1, 1'b1);
    chk("edge_up", 32'(lif.lane_up), 32'd1);
    cyc(1'b1, bad_hdr(), 1'b1, 1'b1);
    chk("edge_state", 32'(lif.state), 32'd1);
    chk("edge_ldc", 32'(lif.lane_down_cnt), 32'd2);

    // Descrambler lock flaps, 300 times
    lock_up();
    pt_seen = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, good_hdr(), 1'b1, 1'b0);
      pt_seen |= lif.descr_passthrough;
      if (i == 0) begin
        chk("flap_down", 32'(lif.lane_up), 32'd0);
        chk("flap_state", 32'(lif.state), 32'd3);
        chk("flap_ldc", 32'(lif.lane_down_cnt), 32'd3);
      end
      cyc(1'b1, good_hdr(), 1'b1, 1'b1);
      pt_seen |= lif.descr_passthrough;
      if (i == 0) chk("flap_back", 32'(lif.lane_up), 32'd1);
    end
    chk("flap_pass", 32'(pt_seen), 32'd0);
    chk("flap_sat", 32'(lif.lane_down_cnt), 32'd255);

    // Enable low: idle, counter held
    cyc(1'b0, good_hdr(), 1'b1, 1'b1);
    chk("dis_state", 32'(lif.state), 32'd0);
    chk("dis_pass", 32'(lif.descr_passthrough), 32'd1);
    chk("dis_up", 32'(lif.lane_up), 32'd0);
    chk("dis_ldc", 32'(lif.lane_down_cnt), 32'd255);

    // Randomized traffic against the model
    lk = 1'b0; bad_rate = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) bad_rate = (i / 400) % 4 == 0 ? 0 : ((i / 400) % 4 == 1 ? 1 : ((i / 400) % 4 == 2 ? 4 : 40));
      if ($urandom_range(0, 29) == 0) lk = ~lk;
      cyc(($urandom_range(0, 499) != 0),
          ($urandom_range(0, 99) < bad_rate) ? bad_hdr() : good_hdr(),
          ($urandom_range(0, 9) != 0), lk);
    end

    // Asynchronous reset in the middle of SLIP
    cyc(1'b0, 2'b01, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 1'b1, 1'b0);
    chk("ar_in_slip", 32'(lif.state), 32'd2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01, 1'(i % 2), 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_state", 32'(lif.state), 32'd0);
    chk("ar_bitslip", 32'(lif.bitslip), 32'd0);
    chk("ar_pass", 32'(lif.descr_passthrough), 32'd1);
    chk("ar_hdr", 32'(lif.hdr_locked), 32'd0);
    chk("ar_up", 32'(lif.lane_up), 32'd0);
    chk("ar_ldc", 32'(lif.lane_down_cnt), 32'd0);
    lif.rx_header_vld = 1'b1;
    @(posedge clk);
    #1;
    lif.rx_header_vld = 1'b0;
    chk("ar_hold", 32'(dut_vec()), 32'(model_vec()));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/interlaken_rx_lane_ctrl.md
Name: interlaken_rx_lane_ctrl

Overview:
Per-lane receive bring-up controller that sequences sync-header (block) lock and descrambler lock for one Interlaken lane. It drives the gearbox bitslip until 64b/67b sync headers are stable. It then releases the descrambler from passthrough, supervises its LOCKED output with a timeout and retry budget, and reports lane-up. It sits between the transceiver RX gearbox and the lane descrambler, one instance per lane.

Parameters:
HDR_LOCK_CNT, 64, consecutive valid headers required to declare header lock
HDR_WIN, 64, header-monitor window length (valid-qualified headers) while header-locked
HDR_BAD_MAX, 16, invalid headers within one window that cause loss of header lock
SLIP_WAIT, 32, cycles to wait after a BITSLIP pulse before re-hunting
DESCR_TIMEOUT, 4096, cycles allowed in DESCR_WAIT for LOCKED to rise
DESCR_RETRIES, 3, passthrough re-arms before falling back to header hunt

Ports:
USER_CLK  input  1  lane user clock; all logic on its rising edge
SYSTEM_RESET_N  input  1  asynchronous, active-low reset
ENABLE  input  1  lane enable; low forces IDLE
RX_HEADER_IN  input  2  sync header from gearbox
RX_HEADER_VALID  input  1  RX_HEADER_IN qualifier; invalid cycles are ignored by all header counters
DESCR_LOCKED_IN  input  1  descrambler LOCKED
BITSLIP  output  1  one-cycle pulse to gearbox
DESCR_PASSTHROUGH  output  1  drives descrambler PASSTHROUGH (high = descrambler held in its reset state)
HDR_LOCKED  output  1  header lock status
LANE_UP  output  1  lane fully aligned
STATE_OUT  output  3  current FSM state encoding
LANE_DOWN_CNT  output  8  saturating count of LANE_UP falling edges

Behaviour:
- Reset (asynchronous assert, synchronous use after release): state IDLE, BITSLIP=0, DESCR_PASSTHROUGH=1, HDR_LOCKED=0, LANE_UP=0, LANE_DOWN_CNT=0, all internal counters 0.
- All outputs are registered. An output change is visible the cycle after the qualifying input edge.
- Valid header: RX_HEADER_VALID=1 and RX_HEADER_IN is 2'b01 or 2'b10. Invalid header: RX_HEADER_VALID=1 and RX_HEADER_IN is 2'b00 or 2'b11.
- States and encodings:
  - IDLE 000: passthrough=1. Go to HUNT when ENABLE=1.
  - HUNT 001: sh_cnt increments on each valid header.
    - Invalid header: BITSLIP pulses for exactly 1 cycle, sh_cnt clears, go to SLIP.
    - sh_cnt reaches HDR_LOCK_CNT: HDR_LOCKED=1, DESCR_PASSTHROUGH=0, timer and retry counters clear, go to DESCR_WAIT.
  - SLIP 010: waits SLIP_WAIT cycles regardless of headers, then returns to HUNT with sh_cnt=0.
  - DESCR_WAIT 011: timer increments every cycle.
    - DESCR_LOCKED_IN=1: LANE_UP=1, go to UP.
    - Timer reaches DESCR_TIMEOUT-1 with retry<DESCR_RETRIES: retry increments, go to REARM.
    - Timer reaches DESCR_TIMEOUT-1 with retry=DESCR_RETRIES: HDR_LOCKED=0, passthrough=1, BITSLIP pulses, go to SLIP.
  - REARM 100: DESCR_PASSTHROUGH=1 for exactly 1 cycle, timer clears, return to DESCR_WAIT.
  - UP 101: LANE_UP=1.
    - DESCR_LOCKED_IN=0: LANE_UP=0, LANE_DOWN_CNT increments (saturates at 255), go to DESCR_WAIT with timer and retry cleared. Passthrough stays 0.
- Header monitor runs in DESCR_WAIT, REARM and UP:
  - win_cnt counts valid-qualified headers 0..HDR_WIN-1; bad_cnt counts invalid ones.
  - bad_cnt reaches HDR_BAD_MAX: loss of header lock. HDR_LOCKED=0, LANE_UP=0, passthrough=1, counters clear, go to HUNT. If LANE_UP was 1, LANE_DOWN_CNT increments.
  - At window end both counters clear.
  - If window end and the HDR_BAD_MAX-th bad header coincide, loss wins.
- Priority, highest first: reset > ENABLE=0 (go to IDLE, passthrough=1, status outputs 0, LANE_DOWN_CNT held) > header loss > descrambler events.
- When header loss and a DESCR_LOCKED_IN fall occur in the same cycle, go to HUNT; LANE_DOWN_CNT increments once.
- RX_HEADER_VALID=0 freezes sh_cnt, win_cnt and bad_cnt. The SLIP and DESCR_WAIT timers still advance.
- Counter widths are $clog2(param)+1 bits; no counter wraps.

Test Plan:
- Reset, then ENABLE=1 with 64 valid headers (2'b01/2'b10 alternating) -> HDR_LOCKED=1 and DESCR_PASSTHROUGH=0 the cycle after the 64th; STATE_OUT=011.
- In HUNT, header 2'b11 after 10 valid -> single 1-cycle BITSLIP; STATE_OUT=010 for 32 cycles; then 001 with sh_cnt=0.
- In DESCR_WAIT, DESCR_LOCKED_IN held 0 (DESCR_TIMEOUT=16 for sim) -> three 1-cycle passthrough pulses 17 cycles apart; the 4th timeout gives BITSLIP, HDR_LOCKED=0, STATE_OUT=010.
- In UP, 15 invalid headers within a 64-header window -> lane stays up. 16th invalid header -> LANE_UP=0, HDR_LOCKED=0, passthrough=1, LANE_DOWN_CNT=1, STATE_OUT=001.
- In UP, DESCR_LOCKED_IN drops for 1 cycle then rises -> LANE_UP low for 1 cycle, passthrough stays 0, LANE_DOWN_CNT increments by 1; repeat 300 times -> LANE_DOWN_CNT=255.
- SYSTEM_RESET_N asserted mid-SLIP with RX_HEADER_VALID toggling -> all outputs return to reset values immediately, without a clock edge.
